// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags a channel as blocked after a
// programmable run of consecutive stall cycles and records the first channel to block.
module axis_stall_detector #(
    parameter int unsigned NUM_CH        = 5,
    parameter logic [NUM_CH-1:0] CH_IS_OUTPUT = 5'b00001,
    parameter int unsigned STALL_THRESH  = 1024,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned IDX_W         = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] tvalid,
    input  logic [NUM_CH-1:0] tready,
    input  logic              clear_first,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              any_block,
    output logic [IDX_W-1:0]  first_ch,
    output logic              first_valid
);

    typedef enum logic [1:0] {IDLE, STALLING, BLOCKED} state_t;

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] block_d;
    logic [NUM_CH-1:0] enter;
    logic [IDX_W-1:0]  first_idx;

    // Output streams stall on backpressure, input streams stall on starvation.
    assign stall = (CH_IS_OUTPUT & tvalid & ~tready) | (~CH_IS_OUTPUT & tready & ~tvalid);

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            if (enable && stall[i]) begin
                unique case (state_q[i])
                    IDLE: begin
                        cnt_d[i]   = CNT_W'(1);
                        state_d[i] = (STALL_THRESH == 1) ? BLOCKED : STALLING;
                    end
                    STALLING: begin
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                        state_d[i] = (cnt_q[i] + CNT_W'(1) == THRESH) ? BLOCKED : STALLING;
                    end
                    BLOCKED: begin
                        cnt_d[i]   = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
                        state_d[i] = BLOCKED;
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            block_d[i] = (state_d[i] == BLOCKED);
        end

        enter = block_d & ~axis_block_sigs;

        // Scan high-to-low so the lowest entering index is the one left standing.
        first_idx = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (enter[i-1]) begin
                first_idx = IDX_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            axis_block_sigs <= '0;
            any_block       <= 1'b0;
            first_ch        <= '0;
            first_valid     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            axis_block_sigs <= block_d;
            any_block       <= |block_d;
            // A fresh block entry on the re-arm edge takes priority over the clear.
            if (|enter && (!first_valid || clear_first)) begin
                first_ch    <= first_idx;
                first_valid <= 1'b1;
            end else if (clear_first) begin
                first_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_stall_detector.sv
// Scoreboard bench for axis_stall_detector: a run-length reference model predicts
// every cycle's outputs; a second instance covers counter saturation.
module tb_axis_stall_detector;

    localparam int NCH = 5;
    localparam int THR = 4;
    localparam logic [NCH-1:0] CH_OUT = 5'b00001;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic [NCH-1:0] tvalid;
    logic [NCH-1:0] tready;
    logic           clear_first;
    logic [NCH-1:0] axis_block_sigs;
    logic           any_block;
    logic [2:0]     first_ch;
    logic           first_valid;

    logic [NCH-1:0] s_tvalid;
    logic [NCH-1:0] s_tready;
    logic [NCH-1:0] s_block;
    logic           s_any;
    logic [2:0]     s_first_ch;
    logic           s_first_valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NCH-1:0] blk;
        logic           any;
        logic [2:0]     fch;
        logic           fv;
    } exp_t;

    exp_t sb[$];

    int             m_run [NCH];
    logic [NCH-1:0] m_blk;
    logic [2:0]     m_fch;
    logic           m_fv;

    always #5 clock = ~clock;

    axis_stall_detector #(
        .NUM_CH(5), .CH_IS_OUTPUT(5'b00001), .STALL_THRESH(4), .CNT_W(16), .IDX_W(3)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .tvalid(tvalid), .tready(tready),
        .clear_first(clear_first), .axis_block_sigs(axis_block_sigs), .any_block(any_block),
        .first_ch(first_ch), .first_valid(first_valid)
    );

    axis_stall_detector #(
        .NUM_CH(5), .CH_IS_OUTPUT(5'b00001), .STALL_THRESH(7), .CNT_W(3), .IDX_W(3)
    ) dut_sat (
        .clock(clock), .reset(reset), .enable(1'b1), .tvalid(s_tvalid), .tready(s_tready),
        .clear_first(1'b0), .axis_block_sigs(s_block), .any_block(s_any),
        .first_ch(s_first_ch), .first_valid(s_first_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a channel is blocked once its run of consecutive stalls reaches THR.
    task automatic model_edge();
        logic [NCH-1:0] nb;
        logic [NCH-1:0] ent;
        logic           st;
        exp_t           e;
        if (reset) begin
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
            m_blk = '0;
            m_fch = '0;
            m_fv  = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st = CH_OUT[i] ? (tvalid[i] && !tready[i]) : (tready[i] && !tvalid[i]);
                m_run[i] = (enable && st) ? m_run[i] + 1 : 0;
                nb[i] = (m_run[i] >= THR);
            end
            ent = nb & ~m_blk;
            if (ent != '0 && (!m_fv || clear_first)) begin
                for (int i = 0; i < NCH; i++) begin
                    if (ent[i]) begin
                        m_fch = 3'(i);
                        break;
                    end
                end
                m_fv = 1'b1;
            end else if (clear_first) begin
                m_fv = 1'b0;
            end
            m_blk = nb;
        end
        e.blk = m_blk;
        e.any = |m_blk;
        e.fch = m_fch;
        e.fv  = m_fv;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check("blk", 32'(axis_block_sigs), 32'(e.blk));
            check("any", 32'(any_block), 32'(e.any));
            check("fch", 32'(first_ch), 32'(e.fch));
            check("fvalid", 32'(first_valid), 32'(e.fv));
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear_first = 1'b0;
        tvalid = '0; tready = '0; s_tvalid = '0; s_tready = '0;
        for (int i = 0; i < NCH; i++) m_run[i] = 0;
        m_blk = '0; m_fch = '0; m_fv = 1'b0;
        steps(2);
        check("rst_blk", 32'(axis_block_sigs), 32'(0));
        check("rst_fv", 32'(first_valid), 32'(0));
        reset = 1'b0; enable = 1'b1;
        step();

        // Output channel 0 backpressured for exactly the threshold.
        tvalid[0] = 1'b1; tready[0] = 1'b0;
        steps(3);
        check("out_pre_blk", 32'(axis_block_sigs), 32'(0));
        step();
        check("out_blk", 32'(axis_block_sigs), 32'(5'b00001));
        check("out_any", 32'(any_block), 32'(1));
        check("out_fch", 32'(first_ch), 32'(0));
        check("out_fv", 32'(first_valid), 32'(1));
        tready[0] = 1'b1;
        step();
        check("out_release", 32'(axis_block_sigs), 32'(0));
        tvalid[0] = 1'b0; tready[0] = 1'b0;
        step();

        // Input channel 2 starved, interrupted by a single transfer.
        tready[2] = 1'b1; tvalid[2] = 1'b0;
        steps(3);
        tvalid[2] = 1'b1;
        step();
        tvalid[2] = 1'b0;
        steps(3);
        check("intr_noblk", 32'(axis_block_sigs[2]), 32'(0));
        tready[2] = 1'b0;
        step();

        // Re-arm, then channels 3 and 1 start starving together.
        clear_first = 1'b1;
        step();
        clear_first = 1'b0;
        check("rearm_fv0", 32'(first_valid), 32'(0));
        tready[1] = 1'b1; tready[3] = 1'b1;
        steps(4);
        check("simul_blk", 32'(axis_block_sigs), 32'(5'b01010));
        check("simul_fch", 32'(first_ch), 32'(1));

        // Channel 1 stays blocked across the re-arm; only channel 4 can capture.
        tready[3] = 1'b0;
        clear_first = 1'b1;
        step();
        clear_first = 1'b0;
        check("rearm2_fv0", 32'(first_valid), 32'(0));
        tready[4] = 1'b1;
        steps(4);
        check("rearm2_fch", 32'(first_ch), 32'(4));
        check("rearm2_fv", 32'(first_valid), 32'(1));
        tready = '0;
        step();

        // Reset aborts a partial count.
        tvalid[0] = 1'b1;
        steps(3);
        reset = 1'b1;
        step();
        check("midrst_blk", 32'(axis_block_sigs), 32'(0));
        check("midrst_fv", 32'(first_valid), 32'(0));
        reset = 1'b0;
        steps(3);
        check("midrst_noblk", 32'(axis_block_sigs), 32'(0));
        step();
        check("midrst_blk4", 32'(axis_block_sigs), 32'(5'b00001));

        // Dropping enable clears block bits but keeps the first-block record.
        enable = 1'b0;
        step();
        check("en_blk", 32'(axis_block_sigs), 32'(0));
        check("en_any", 32'(any_block), 32'(0));
        check("en_fv", 32'(first_valid), 32'(1));
        enable = 1'b1;
        tvalid = '0;
        step();

        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(3) == 0) begin
                    tvalid[c] = 1'($urandom_range(1));
                    tready[c] = 1'($urandom_range(1));
                end
            end
            clear_first = ($urandom_range(15) == 0);
            enable = ($urandom_range(40) != 0);
            step();
        end
        clear_first = 1'b0; enable = 1'b1; tvalid = '0; tready = '0;
        step();

        // Saturating counter on the narrow instance.
        s_tvalid[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            check("sat_blk", 32'(s_block[0]), 32'(k >= 7));
            check("sat_cnt", 32'(dut_sat.cnt_q[0]), 32'((k < 7) ? k : 7));
        end
        s_tvalid[0] = 1'b0;
        @(posedge clock);
        #1;
        check("sat_release", 32'(s_block[0]), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
